// File: rtl/linebuffer_window9_pkg.sv
// lb_pkg: shared constants and types for the 9x9 streaming window generator.
//   IMG_W/IMG_H : image geometry in pixels
//   K           : window edge, NWIN = K*K window entries
//   PIX_W       : pixel width, pix_t is one unsigned pixel
//   ROW_AW      : width of a column address inside one stored row
//   COL_AW      : width of a row index within a frame
package lb_pkg;
    localparam int unsigned IMG_W  = 28;
    localparam int unsigned IMG_H  = 28;
    localparam int unsigned K      = 9;
    localparam int unsigned PIX_W  = 7;

    localparam int unsigned NWIN   = K * K;
    localparam int unsigned ROW_AW = $clog2(IMG_W);
    localparam int unsigned COL_AW = $clog2(IMG_H);

    typedef logic [PIX_W-1:0] pix_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } lb_state_t;
endpackage

// File: rtl/linebuffer_window9_if.sv
// linebuffer_window9_if: pixel stream in, window stream out.
//   pix_valid/pix_sof/pix_data : raster pixel stream (sof qualified by valid)
//   win_valid/win_data         : registered KxK window, entry i*K+j = pixel(wr+i, wc+j)
//   win_row/win_col            : top-left coordinate (wr, wc) of the window
//   frame_done                 : pulses with the last window of a frame
//   master = pixel producer / window consumer, slave = window generator
interface linebuffer_window9_if;
    import lb_pkg::*;

    logic                pix_valid;
    logic                pix_sof;
    pix_t                pix_data;
    logic                win_valid;
    pix_t                win_data [0:NWIN-1];
    logic [COL_AW-1:0]   win_row;
    logic [ROW_AW-1:0]   win_col;
    logic                frame_done;

    modport master (
        output pix_valid, pix_sof, pix_data,
        input  win_valid, win_data, win_row, win_col, frame_done
    );

    modport slave (
        input  pix_valid, pix_sof, pix_data,
        output win_valid, win_data, win_row, win_col, frame_done
    );
endinterface

// File: rtl/linebuffer_window9_line_row_mem.sv
// line_row_mem: one image row of storage, IMG_W x PIX_W.
//   clk    : clock
//   i_we   : write enable
//   i_addr : column address (shared by read and write)
//   i_data : pixel written at i_addr
//   o_data : pixel previously stored at i_addr (read-before-write)
// Contents are not reset; every location is rewritten before it is used.
module line_row_mem
    import lb_pkg::*;
(
    input  logic              clk,
    input  logic              i_we,
    input  logic [ROW_AW-1:0] i_addr,
    input  pix_t              i_data,
    output pix_t              o_data
);
    pix_t r_mem [0:IMG_W-1];

    assign o_data = r_mem[i_addr];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_data;
        end
    end
endmodule

// File: rtl/linebuffer_window9.sv
// linebuffer_window9: turns a raster pixel stream into KxK windows.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   lb    : stream interface (slave side), see linebuffer_window9_if
// K-1 chained row memories hold the previous rows; each accepted pixel shifts
// the window one column and appends rows r-(K-1)..r at column K-1.
module linebuffer_window9
    import lb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    linebuffer_window9_if.slave   lb
);
    localparam logic [COL_AW-1:0] LAST_ROW = COL_AW'(IMG_H - 1);
    localparam logic [ROW_AW-1:0] LAST_COL = ROW_AW'(IMG_W - 1);
    localparam logic [COL_AW-1:0] KM1_R    = COL_AW'(K - 1);
    localparam logic [ROW_AW-1:0] KM1_C    = ROW_AW'(K - 1);

    lb_state_t          r_state, w_state_nxt;
    logic [COL_AW-1:0]  r_row;
    logic [ROW_AW-1:0]  r_col;

    logic               w_sof, w_accept, w_last_col, w_last_px, w_win_ok;
    logic [COL_AW-1:0]  w_r;
    logic [ROW_AW-1:0]  w_c;

    // w_chain[0] is the incoming pixel, w_chain[k] is the pixel k rows above.
    pix_t               w_chain [0:K-1];

    pix_t               r_win [0:NWIN-1];
    logic               r_win_valid, r_frame_done;
    logic [COL_AW-1:0]  r_win_row;
    logic [ROW_AW-1:0]  r_win_col;

    // A start-of-frame pixel is always accepted and forced to position (0,0).
    assign w_sof      = lb.pix_valid & lb.pix_sof;
    assign w_accept   = w_sof | (lb.pix_valid & (r_state == ST_RUN));
    assign w_r        = w_sof ? '0 : r_row;
    assign w_c        = w_sof ? '0 : r_col;
    assign w_last_col = (w_c == LAST_COL);
    assign w_last_px  = w_last_col & (w_r == LAST_ROW);
    // Columns below K-1 hold data wrapped in from the previous row: masked here.
    assign w_win_ok   = (w_r >= KM1_R) & (w_c >= KM1_C);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_sof) begin
            w_state_nxt = ST_RUN;
        end
        if (w_accept && w_last_px) begin
            w_state_nxt = ST_DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_accept) begin
            if (w_last_col) begin
                r_col <= '0;
                r_row <= w_last_px ? '0 : w_r + 1'b1;
            end else begin
                r_col <= w_c + 1'b1;
                r_row <= w_r;
            end
        end
    end

    assign w_chain[0] = lb.pix_data;

    for (genvar k = 0; k < K - 1; k++) begin : g_rows
        line_row_mem u_row (
            .clk    (clk),
            .i_we   (w_accept),
            .i_addr (w_c),
            .i_data (w_chain[k]),
            .o_data (w_chain[k+1])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned n = 0; n < NWIN; n++) begin
                r_win[n] <= '0;
            end
            r_win_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_win_row    <= '0;
            r_win_col    <= '0;
        end else begin
            r_win_valid  <= w_accept & w_win_ok;
            r_frame_done <= w_accept & w_win_ok & w_last_px;
            if (w_accept) begin
                for (int unsigned i = 0; i < K; i++) begin
                    for (int unsigned j = 0; j < K - 1; j++) begin
                        r_win[i*K+j] <= r_win[i*K+j+1];
                    end
                    // Window row i is K-1-i rows above the incoming pixel.
                    r_win[i*K+K-1] <= w_chain[K-1-i];
                end
                if (w_win_ok) begin
                    r_win_row <= w_r - KM1_R;
                    r_win_col <= w_c - KM1_C;
                end
            end
        end
    end

    assign lb.win_valid  = r_win_valid;
    assign lb.win_data   = r_win;
    assign lb.win_row    = r_win_row;
    assign lb.win_col    = r_win_col;
    assign lb.frame_done = r_frame_done;
endmodule

// File: tb/tb_linebuffer_window9.sv
// tb_linebuffer_window9: random-stimulus bench for linebuffer_window9.
// A frame-array reference model derives every expected window from the
// pixels it has seen; DUT outputs are compared 1 ns after each rising edge.
module tb_linebuffer_window9;
    import lb_pkg::*;

    localparam int W  = int'(IMG_W);
    localparam int H  = int'(IMG_H);
    localparam int KK = int'(K);
    localparam int NW = int'(NWIN);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    linebuffer_window9_if lb();

    linebuffer_window9 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .lb    (lb.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference model state
    int img [0:H-1][0:W-1];
    bit m_active = 1'b0;
    int m_r = 0;
    int m_c = 0;
    bit e_valid, e_done, e_zero;
    int e_row, e_col;
    int e_win [0:NW-1];

    // Per-test observations
    int n_win, n_done, n_px;
    int f_at, f_row, f_col, f_d0, f_d9, f_d80;

    task automatic clear_stats();
        n_win = 0; n_done = 0; n_px = 0;
        f_at = -1; f_row = -1; f_col = -1; f_d0 = -1; f_d9 = -1; f_d80 = -1;
    endtask

    task automatic step(input bit rst, input bit v, input bit sof, input int d);
        @(negedge clk);
        rst_n        = rst;
        lb.pix_valid = v;
        lb.pix_sof   = sof;
        lb.pix_data  = pix_t'(d);
        @(posedge clk);
        e_valid = 1'b0;
        e_done  = 1'b0;
        e_zero  = 1'b0;
        if (!rst) begin
            m_active = 1'b0; m_r = 0; m_c = 0; e_zero = 1'b1;
        end else if (v && (sof || m_active)) begin
            if (sof) begin
                m_r = 0; m_c = 0; m_active = 1'b1;
            end
            n_px++;
            img[m_r][m_c] = d % 128;
            if (m_r >= KK - 1 && m_c >= KK - 1) begin
                e_valid = 1'b1;
                e_row   = m_r - (KK - 1);
                e_col   = m_c - (KK - 1);
                e_done  = (m_r == H - 1) && (m_c == W - 1);
                for (int i = 0; i < KK; i++)
                    for (int j = 0; j < KK; j++)
                        e_win[i*KK+j] = img[e_row+i][e_col+j];
            end
            if (m_c == W - 1) begin
                m_c = 0;
                if (m_r == H - 1) begin
                    m_r = 0; m_active = 1'b0;
                end else begin
                    m_r++;
                end
            end else begin
                m_c++;
            end
        end
        #1;
        if (e_zero) begin
            check("rst_win_valid", int'(lb.win_valid), 0);
            check("rst_frame_done", int'(lb.frame_done), 0);
            check("rst_win_row", int'(lb.win_row), 0);
            check("rst_win_col", int'(lb.win_col), 0);
            for (int i = 0; i < NW; i++)
                check($sformatf("rst_win_data[%0d]", i), int'(lb.win_data[i]), 0);
        end else begin
            check("win_valid", int'(lb.win_valid), int'(e_valid));
            check("frame_done", int'(lb.frame_done), int'(e_done));
            if (e_valid) begin
                check("win_row", int'(lb.win_row), e_row);
                check("win_col", int'(lb.win_col), e_col);
                for (int i = 0; i < NW; i++)
                    check($sformatf("win_data[%0d]", i), int'(lb.win_data[i]), e_win[i]);
            end
        end
        if (lb.win_valid) begin
            if (n_win == 0) begin
                f_at  = n_px;
                f_row = int'(lb.win_row);
                f_col = int'(lb.win_col);
                f_d0  = int'(lb.win_data[0]);
                f_d9  = int'(lb.win_data[9]);
                f_d80 = int'(lb.win_data[80]);
            end
            n_win++;
        end
        if (lb.frame_done) n_done++;
    endtask

    // Send n pixels of one frame; ramp gives pixel index mod 128, otherwise random.
    // Bubbles carry a random pix_sof that must be ignored because pix_valid is low.
    task automatic send(input bit with_sof, input int n, input int bubble_pct, input bit ramp);
        int d;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 6 && $urandom_range(99) < bubble_pct; b++)
                step(1'b1, 1'b0, 1'($urandom_range(1)), int'($urandom_range(127)));
            d = ramp ? (i % 128) : int'($urandom_range(127));
            step(1'b1, 1'b1, with_sof && (i == 0), d);
        end
    endtask

    task automatic check_ramp_first(input string tag, input int at);
        check({tag, "_first_at"}, f_at, at);
        check({tag, "_first_row"}, f_row, 0);
        check({tag, "_first_col"}, f_col, 0);
        check({tag, "_first_d0"}, f_d0, 0);
        check({tag, "_first_d9"}, f_d9, 28);
        check({tag, "_first_d80"}, f_d80, 104);
    endtask

    initial begin
        lb.pix_valid = 1'b0;
        lb.pix_sof   = 1'b0;
        lb.pix_data  = '0;

        step(1'b0, 1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 1'b1, 3);

        // Pixels before any start-of-frame are ignored
        clear_stats();
        send(1'b0, 40, 0, 1'b0);
        check("idle_nwin", n_win, 0);

        // Contiguous ramp frame
        clear_stats();
        send(1'b1, W * H, 0, 1'b1);
        check("ramp_nwin", n_win, 400);
        check("ramp_ndone", n_done, 1);
        check_ramp_first("ramp", 233);

        // Ramp frame with 50% bubbles
        clear_stats();
        send(1'b1, W * H, 50, 1'b1);
        check("bub_nwin", n_win, 400);
        check("bub_ndone", n_done, 1);
        check_ramp_first("bub", 233);

        // Pixels after the frame end without a new start are ignored
        clear_stats();
        send(1'b0, 30, 0, 1'b0);
        check("done_nwin", n_win, 0);

        // Mid-frame restart at stream index 100
        clear_stats();
        send(1'b1, 100, 20, 1'b0);
        send(1'b1, W * H, 20, 1'b0);
        check("restart_nwin", n_win, 400);
        check("restart_ndone", n_done, 1);
        check("restart_first_at", f_at, 333);

        // Reset mid-frame, then pixels without start, then a full frame
        clear_stats();
        send(1'b1, 150, 0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 5);
        send(1'b0, 60, 0, 1'b0);
        check("rstmid_nwin", n_win, 0);
        send(1'b1, W * H, 30, 1'b0);
        check("rstmid_full_nwin", n_win, 400);
        check("rstmid_ndone", n_done, 1);

        // Back-to-back frames with no gap
        clear_stats();
        send(1'b1, W * H, 0, 1'b0);
        send(1'b1, W * H, 0, 1'b0);
        check("b2b_nwin", n_win, 800);
        check("b2b_ndone", n_done, 2);

        step(1'b1, 1'b0, 1'b0, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
